nios_system_nios2_cpu_debug_monitor_mem: RTL and testbench
==========================================================

// Module: nios_system_nios2_cpu_debug_monitor_mem
// PURPOSE
//  Sits directly downstream of the debug-slave sysclk sync stage; consumes jdo and the ocimem take_action strobes.
//  Executes JTAG-originated reads/writes into an on-chip monitor RAM and returns MonDReg, monitor_ready and monitor_error.
//  The CPU reaches the same RAM through an Avalon-MM slave port (debug monitor code/data).
//  Single-port RAM is shared; JTAG has priority.
// PARAMETERS
//  ADDR_W     8     word address width; DEPTH = 2**ADDR_W 32-bit words
//  INIT_FILE  ""    optional RAM init file ("" = none; contents otherwise undefined)
// PORTS
//  clk                      in   1       system clock
//  reset                    in   1       async reset, active high
//  jdo                      in   38      JTAG data word, stable while any strobe is high
//  take_action_ocimem_a     in   1       1-cycle strobe: load address / optional read
//  take_no_action_ocimem_a  in   1       1-cycle strobe: read at current address, post-increment
//  take_action_ocimem_b     in   1       1-cycle strobe: write at current address, post-increment
//  avs_address              in   ADDR_W  Avalon word address
//  avs_read                 in   1       Avalon read request
//  avs_write                in   1       Avalon write request
//  avs_writedata            in   32      Avalon write data
//  avs_byteenable           in   4       Avalon byte enables
//  avs_readdata             out  32      Avalon read data
//  avs_waitrequest          out  1       Avalon stall
//  MonDReg                  out  32      last JTAG read data
//  monitor_ready            out  1       JTAG access complete
//  monitor_error            out  1       sticky JTAG overrun flag
// BEHAVIOUR
//  Reset: MonDReg=0, monitor_ready=0, monitor_error=0, avs_readdata=0, avs_waitrequest=0, MonAReg=0, FSM=IDLE.
//  Reset does not clear RAM. Reset mid-access aborts it with no RAM write.
//  JTAG decode (MonAReg is the internal ADDR_W address register):
//   - take_action_ocimem_a: MonAReg<=jdo[ADDR_W+16:17]. If jdo[34]=1, queue a read.
//     If jdo[33]=1, clear monitor_error.
//   - take_no_action_ocimem_a: queue a read at MonAReg.
//   - take_action_ocimem_b: queue a write of jdo[34:3] to MonAReg, all bytes.
//   - MonAReg increments after every JTAG read/write and wraps DEPTH-1 -> 0.
//  FSM states IDLE, J_RD, J_WR, A_RD:
//   - IDLE -> J_RD/J_WR when a JTAG op is queued. This has priority over Avalon in the same cycle.
//   - IDLE -> A_RD on avs_read with no JTAG op queued.
//   - J_RD: RAM read (1-cycle latency). Next cycle MonDReg<=q, monitor_ready<=1, -> IDLE.
//   - J_WR: RAM write in this cycle. Next cycle monitor_ready<=1, -> IDLE.
//   - A_RD: avs_readdata<=q with waitrequest low that cycle, -> IDLE. Avalon read latency = 2 cycles.
//  Avalon write in IDLE with no JTAG op queued: completes in 1 cycle with waitrequest=0, byte-enables honoured.
//  avs_waitrequest=1 combinationally whenever avs_read/avs_write is high and the RAM is taken:
//   - a JTAG op is queued, or FSM in J_RD/J_WR, or
//   - first cycle of an Avalon read.
//  monitor_ready: cleared on the cycle any ocimem strobe arrives; set on JTAG completion.
//   An address-only ocimem_a (jdo[34]=0) sets it on the next cycle.
//  Overrun: strobe arrives while a JTAG op is queued or in J_RD/J_WR.
//   - New op is dropped, monitor_error<=1 (sticky).
//   - Address load of a dropped ocimem_a is also ignored.
//  Strobe during A_RD: queued, starts the cycle after A_RD. Not an overrun.
//  At most one queued JTAG op.
// CONFIGURATION
//  DEBUG_MON_ROM_PROTECT_EN defined:
//   - Avalon writes to the upper half of the address space (addr MSB=1) are accepted (waitrequest=0) but discarded.
//   - JTAG writes are unaffected.
//  Undefined: the whole RAM is Avalon-writable.
// TESTING
//  1. Reset asserted mid J_WR -> outputs at reset values; RAM word unchanged.
//  2. ocimem_a jdo[24:17]=8'h10, jdo[34]=0; then ocimem_b jdo[34:3]=32'hDEADBEEF
//     -> monitor_ready=1 two cycles after the strobe; Avalon read @0x10 returns DEADBEEF.
//  3. ocimem_a addr 0xFF + read, then no_action_ocimem_a
//     -> MonDReg = RAM[0xFF] then RAM[0x00] (wrap); monitor_ready pulses per op.
//  4. ocimem_b and avs_write@0x20 in the same cycle
//     -> waitrequest=1 for 2 cycles, JTAG data written first, Avalon write lands after; RAM[0x20]=avs data.
//  5. Two ocimem_b strobes back-to-back
//     -> second dropped, monitor_error=1; stays 1 until ocimem_a with jdo[33]=1.
//  6. With DEBUG_MON_ROM_PROTECT_EN, avs_write@0x80 of 32'h12345678
//     -> RAM[0x80] unchanged; same write without macro -> RAM[0x80]=12345678.

Source files
------------

// File: rtl/nios_system_nios2_cpu_debug_monitor_mem.sv
// nios_system_nios2_cpu_debug_monitor_mem: debug monitor RAM shared by JTAG (priority) and an Avalon-MM slave.
//
// Ports:
//   clk, reset                      system clock, async active-high reset
//   jdo[37:0]                       JTAG data word, stable while any ocimem strobe is high
//   take_action_ocimem_a            load MonAReg from jdo, optional read (jdo[34]), error clear (jdo[33])
//   take_no_action_ocimem_a         read at MonAReg, post-increment
//   take_action_ocimem_b            write jdo[34:3] at MonAReg, post-increment
//   avs_address/read/write/         Avalon-MM word-addressed slave port with byte enables
//   avs_writedata/byteenable
//   avs_readdata, avs_waitrequest   Avalon read data (valid when waitrequest drops), stall
//   MonDReg                         data of the last JTAG read
//   monitor_ready                   JTAG access complete
//   monitor_error                   sticky JTAG overrun flag
//
// Optional feature: define DEBUG_MON_ROM_PROTECT_EN to make the upper half of the RAM
// read-only from Avalon (writes accepted and discarded); JTAG writes stay unrestricted.
module nios_system_nios2_cpu_debug_monitor_mem #(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, J_RD, J_WR, A_RD} state_t;

  logic [31:0]       mem [DEPTH];
  state_t            state, state_nx;
  logic [ADDR_W-1:0] mon_a, ram_addr;
  logic [31:0]       jw_data, ram_wdata, rd_word;
  logic [3:0]        ram_be;
  logic              ram_we, pend_v, pend_wr, ao_pend;
  logic              strb, j_busy, busy, ovr, acc, new_rd, new_wr, jop, jop_rd;
  logic              a_rd, a_wr, a_prot;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

`ifdef DEBUG_MON_ROM_PROTECT_EN
  assign a_prot = avs_address[ADDR_W-1];
`else
  assign a_prot = 1'b0;
`endif

  // A strobe is only accepted when nothing JTAG-side is outstanding; the
  // pending slot exists solely to hold an op that arrives during an Avalon read.
  assign strb   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign j_busy = state == J_RD || state == J_WR;
  assign busy   = pend_v | j_busy;
  assign ovr    = strb & busy;
  assign acc    = strb & ~busy;
  assign new_rd = acc & (take_action_ocimem_a ? jdo[34] : take_no_action_ocimem_a);
  assign new_wr = acc & ~take_action_ocimem_a & ~take_no_action_ocimem_a;
  assign jop    = pend_v | new_rd | new_wr;
  assign jop_rd = pend_v ? ~pend_wr : new_rd;
  assign a_rd   = state == IDLE && !jop && avs_read;
  assign a_wr   = state == IDLE && !jop && avs_write && !avs_read;
  assign rd_word = mem[ram_addr];

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nx;

  always_comb begin
    state_nx = (state == IDLE && jop) ? (jop_rd ? J_RD : J_WR) : a_rd ? A_RD : IDLE;
  end

  // The read occupies the first Avalon cycle; waitrequest drops in A_RD when
  // avs_readdata already holds the word. Reset gates the write strobe so an
  // aborted J_WR never lands.
  always_comb begin
    ram_addr        = j_busy ? mon_a : avs_address;
    ram_wdata       = j_busy ? jw_data : avs_writedata;
    ram_be          = j_busy ? 4'hF : avs_byteenable;
    ram_we          = !reset && (state == J_WR || (a_wr && !a_prot));
    avs_waitrequest = (avs_read || avs_write) && (j_busy || (state == IDLE && (jop || avs_read)));
  end

  always_ff @(posedge clk)
    if (ram_we)
      for (int i = 0; i < 4; i++)
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mon_a         <= '0;
      jw_data       <= '0;
      pend_v        <= 1'b0;
      pend_wr       <= 1'b0;
      ao_pend       <= 1'b0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      avs_readdata  <= '0;
    end else begin
      mon_a         <= (acc && take_action_ocimem_a) ? jdo[ADDR_W+16:17] : j_busy ? mon_a + ADDR_W'(1) : mon_a;
      jw_data       <= new_wr ? jdo[34:3] : jw_data;
      pend_v        <= state == A_RD && (new_rd || new_wr);
      pend_wr       <= new_wr;
      ao_pend       <= acc && take_action_ocimem_a && !jdo[34];
      monitor_ready <= (j_busy || ao_pend) ? 1'b1 : strb ? 1'b0 : monitor_ready;
      monitor_error <= ovr ? 1'b1 : (acc && take_action_ocimem_a && jdo[33]) ? 1'b0 : monitor_error;
      MonDReg       <= state == J_RD ? rd_word : MonDReg;
      avs_readdata  <= a_rd ? rd_word : avs_readdata;
    end
endmodule

// File: tb/tb_nios_system_nios2_cpu_debug_monitor_mem.sv
// tb_nios_system_nios2_cpu_debug_monitor_mem: scoreboard bench for the debug monitor RAM.
module tb_nios_system_nios2_cpu_debug_monitor_mem;
  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        ta_a, tna_a, ta_b;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata, MonDReg;
  logic        avs_waitrequest, monitor_ready, monitor_error;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] exp_q [$];

  nios_system_nios2_cpu_debug_monitor_mem #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_no_action_ocimem_a(tna_a), .take_action_ocimem_b(ta_b),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd, input logic clr);
    logic [37:0] j;
    j = '0;
    j[24:17] = a;
    j[34] = rd;
    j[33] = clr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // k: 0 = ocimem_a, 1 = no_action_ocimem_a, 2 = ocimem_b; returns one cycle after the strobe edge
  task automatic strobe(input int k, input logic [37:0] j);
    @(negedge clk);
    jdo = j; ta_a = (k == 0); tna_a = (k == 1); ta_b = (k == 2);
    @(negedge clk);
    ta_a = 0; tna_a = 0; ta_b = 0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!monitor_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic avs_rd(input logic [7:0] a, output logic [31:0] d, output int w);
    @(negedge clk);
    avs_address = a; avs_read = 1; w = 0;
    #1;
    while (avs_waitrequest && w < 20) begin
      @(negedge clk); #1; w++;
    end
    d = avs_readdata;
    @(negedge clk);
    avs_read = 0;
  endtask

  task automatic avs_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, output int w);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1; w = 0;
    #1;
    while (avs_waitrequest && w < 20) begin
      @(negedge clk); #1; w++;
    end
    @(negedge clk);
    avs_write = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (MonDReg !== 32'h0) begin errors++; $display("FAIL reset_mondreg got %h want 0", MonDReg); end
    if (monitor_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", monitor_ready); end
    if (monitor_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", monitor_error); end
    if (avs_readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h want 0", avs_readdata); end
    if (avs_waitrequest !== 1'b0) begin errors++; $display("FAIL reset_wait got %b want 0", avs_waitrequest); end
    reset = 0;
  endtask

  task automatic test_jtag_write();
    logic [31:0] d, e;
    int w;
    strobe(0, jdo_a(8'h10, 0, 0));
    checks++;
    if (monitor_ready !== 1'b0) begin errors++; $display("FAIL addr_ready_early got %b want 0", monitor_ready); end
    @(negedge clk);
    checks++;
    if (monitor_ready !== 1'b1) begin errors++; $display("FAIL addr_ready got %b want 1", monitor_ready); end
    strobe(2, jdo_b(32'hDEADBEEF));
    ref_mem[8'h10] = 32'hDEADBEEF;
    checks++;
    if (monitor_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_clear got %b want 0", monitor_ready); end
    @(negedge clk);
    checks++;
    if (monitor_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got %b want 1", monitor_ready); end
    exp_q.push_back(ref_mem[8'h10]);
    avs_rd(8'h10, d, w);
    e = exp_q.pop_front();
    checks += 2;
    if (d !== e) begin errors++; $display("FAIL avs_rd_10 got %h want %h", d, e); end
    if (w !== 1) begin errors++; $display("FAIL avs_rd_wait got %0d want 1", w); end
  endtask

  task automatic test_read_wrap();
    logic [31:0] e;
    int w, n;
    avs_wr(8'hFF, 32'hA5A500FF, 4'hF, w); ref_mem[8'hFF] = 32'hA5A500FF;
    avs_wr(8'h00, 32'h12340000, 4'hF, w); ref_mem[8'h00] = 32'h12340000;
    strobe(0, jdo_a(8'hFF, 1, 0));
    exp_q.push_back(ref_mem[8'hFF]);
    checks++;
    if (monitor_ready !== 1'b0) begin errors++; $display("FAIL rd_ff_ready_clear got %b want 0", monitor_ready); end
    wait_ready(n);
    e = exp_q.pop_front();
    checks += 2;
    if (n !== 1) begin errors++; $display("FAIL rd_ff_latency got %0d want 1", n); end
    if (MonDReg !== e) begin errors++; $display("FAIL rd_ff_data got %h want %h", MonDReg, e); end
    strobe(1, '0);
    exp_q.push_back(ref_mem[8'h00]);
    checks++;
    if (monitor_ready !== 1'b0) begin errors++; $display("FAIL rd_wrap_ready_clear got %b want 0", monitor_ready); end
    wait_ready(n);
    e = exp_q.pop_front();
    checks += 2;
    if (n !== 1) begin errors++; $display("FAIL rd_wrap_latency got %0d want 1", n); end
    if (MonDReg !== e) begin errors++; $display("FAIL rd_wrap_data got %h want %h", MonDReg, e); end
  endtask

  task automatic test_collision();
    logic [31:0] d, e;
    int w, n;
    strobe(0, jdo_a(8'h20, 0, 0));
    wait_ready(n);
    @(negedge clk);
    ta_b = 1; jdo = jdo_b(32'hCAFEF00D);
    avs_address = 8'h20; avs_writedata = 32'h0BADC0DE; avs_byteenable = 4'hF; avs_write = 1; w = 0;
    #1;
    while (avs_waitrequest && w < 20) begin
      @(negedge clk); ta_b = 0; #1; w++;
    end
    ta_b = 0;
    @(negedge clk);
    avs_write = 0;
    ref_mem[8'h20] = 32'h0BADC0DE;
    checks += 2;
    if (w !== 2) begin errors++; $display("FAIL collide_wait got %0d want 2", w); end
    if (monitor_ready !== 1'b1) begin errors++; $display("FAIL collide_ready got %b want 1", monitor_ready); end
    exp_q.push_back(ref_mem[8'h20]);
    avs_rd(8'h20, d, w);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("FAIL collide_data got %h want %h", d, e); end
  endtask

  task automatic test_overrun();
    logic [31:0] d, e;
    int w, n;
    avs_wr(8'h21, 32'h21212121, 4'hF, w); ref_mem[8'h21] = 32'h21212121;
    avs_wr(8'h22, 32'h22222222, 4'hF, w); ref_mem[8'h22] = 32'h22222222;
    avs_wr(8'h31, 32'h31313131, 4'hF, w); ref_mem[8'h31] = 32'h31313131;
    strobe(0, jdo_a(8'h21, 0, 0));
    wait_ready(n);
    @(negedge clk);
    ta_b = 1; jdo = jdo_b(32'h11110001);
    @(negedge clk);
    jdo = jdo_b(32'h11110002);
    @(negedge clk);
    ta_b = 0;
    ref_mem[8'h21] = 32'h11110001;
    checks++;
    if (monitor_error !== 1'b1) begin errors++; $display("FAIL ovr_error got %b want 1", monitor_error); end
    wait_ready(n);
    exp_q.push_back(ref_mem[8'h21]);
    exp_q.push_back(ref_mem[8'h22]);
    avs_rd(8'h21, d, w);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("FAIL ovr_first got %h want %h", d, e); end
    avs_rd(8'h22, d, w);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("FAIL ovr_dropped got %h want %h", d, e); end
    strobe(0, jdo_a(8'h30, 0, 0));
    checks++;
    if (monitor_error !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", monitor_error); end
    wait_ready(n);
    strobe(0, jdo_a(8'h30, 0, 1));
    checks++;
    if (monitor_error !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", monitor_error); end
    wait_ready(n);
    // write at 0x30, then an overrunning address load that must be ignored
    @(negedge clk);
    ta_b = 1; jdo = jdo_b(32'h30303030);
    @(negedge clk);
    ta_b = 0; ta_a = 1; jdo = jdo_a(8'h60, 1, 0);
    @(negedge clk);
    ta_a = 0;
    ref_mem[8'h30] = 32'h30303030;
    wait_ready(n);
    strobe(1, '0);
    exp_q.push_back(ref_mem[8'h31]);
    wait_ready(n);
    e = exp_q.pop_front();
    checks += 2;
    if (MonDReg !== e) begin errors++; $display("FAIL ovr_addr_ignored got %h want %h", MonDReg, e); end
    if (monitor_error !== 1'b1) begin errors++; $display("FAIL ovr_addr_error got %b want 1", monitor_error); end
    strobe(0, jdo_a(8'h30, 0, 1));
    wait_ready(n);
  endtask

  task automatic test_byteenable();
    logic [31:0] e;
    int w, n;
    avs_wr(8'h40, 32'h11223344, 4'hF, w);
    avs_wr(8'h40, 32'hAABBCCDD, 4'b0101, w);
    ref_mem[8'h40] = 32'h11BB33DD;
    checks++;
    if (w !== 0) begin errors++; $display("FAIL be_wait got %0d want 0", w); end
    strobe(0, jdo_a(8'h40, 1, 0));
    exp_q.push_back(ref_mem[8'h40]);
    wait_ready(n);
    e = exp_q.pop_front();
    checks++;
    if (MonDReg !== e) begin errors++; $display("FAIL be_data got %h want %h", MonDReg, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e;
    logic [7:0]  a;
    int w, n;
    strobe(0, jdo_a(8'h40, 0, 0));
    wait_ready(n);
    exp_q.push_back(ref_mem[8'h10]);
    exp_q.push_back(ref_mem[8'h40]);
    @(negedge clk);
    avs_address = 8'h10; avs_read = 1;
    #1;
    checks++;
    if (avs_waitrequest !== 1'b1) begin errors++; $display("FAIL b2b_wait_first got %b want 1", avs_waitrequest); end
    @(negedge clk);
    tna_a = 1;
    #1;
    e = exp_q.pop_front();
    checks += 2;
    if (avs_waitrequest !== 1'b0) begin errors++; $display("FAIL b2b_wait_ard got %b want 0", avs_waitrequest); end
    if (avs_readdata !== e) begin errors++; $display("FAIL b2b_avs_data got %h want %h", avs_readdata, e); end
    @(negedge clk);
    tna_a = 0; avs_read = 0;
    wait_ready(n);
    e = exp_q.pop_front();
    checks += 3;
    if (n !== 2) begin errors++; $display("FAIL b2b_jtag_latency got %0d want 2", n); end
    if (MonDReg !== e) begin errors++; $display("FAIL b2b_jtag_data got %h want %h", MonDReg, e); end
    if (monitor_error !== 1'b0) begin errors++; $display("FAIL b2b_no_overrun got %b want 0", monitor_error); end
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(127, 0));
      d = $urandom;
      avs_wr(a, d, 4'hF, w);
      ref_mem[a] = d;
      strobe(0, jdo_a(a, 1, 0));
      exp_q.push_back(ref_mem[a]);
      wait_ready(n);
      e = exp_q.pop_front();
      checks++;
      if (MonDReg !== e) begin errors++; $display("FAIL rand_jrd[%0d] addr %h got %h want %h", i, a, MonDReg, e); end
      d = $urandom;
      strobe(2, jdo_b(d));
      ref_mem[a + 8'd1] = d;
      wait_ready(n);
      exp_q.push_back(ref_mem[a + 8'd1]);
      avs_rd(a + 8'd1, d, w);
      e = exp_q.pop_front();
      checks++;
      if (d !== e) begin errors++; $display("FAIL rand_ard[%0d] addr %h got %h want %h", i, a + 8'd1, d, e); end
    end
  endtask

  task automatic test_rom_protect();
    logic [31:0] d, e;
    int w, n;
    strobe(0, jdo_a(8'h80, 0, 0));
    wait_ready(n);
    strobe(2, jdo_b(32'h55AA55AA));
    wait_ready(n);
    ref_mem[8'h80] = 32'h55AA55AA;
    avs_wr(8'h80, 32'h12345678, 4'hF, w);
`ifndef DEBUG_MON_ROM_PROTECT_EN
    ref_mem[8'h80] = 32'h12345678;
`endif
    checks++;
    if (w !== 0) begin errors++; $display("FAIL prot_wait got %0d want 0", w); end
    exp_q.push_back(ref_mem[8'h80]);
    avs_rd(8'h80, d, w);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("FAIL prot_data got %h want %h", d, e); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d, e;
    int w, n;
    avs_wr(8'h50, 32'h600DD00D, 4'hF, w);
    ref_mem[8'h50] = 32'h600DD00D;
    strobe(0, jdo_a(8'h50, 0, 0));
    wait_ready(n);
    @(negedge clk);
    ta_b = 1; jdo = jdo_b(32'hBAD0BAD0);
    @(negedge clk);
    ta_b = 0;
    #2 reset = 1;
    #1;
    checks += 5;
    if (monitor_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b want 0", monitor_ready); end
    if (monitor_error !== 1'b0) begin errors++; $display("FAIL rstmid_error got %b want 0", monitor_error); end
    if (MonDReg !== 32'h0) begin errors++; $display("FAIL rstmid_mondreg got %h want 0", MonDReg); end
    if (avs_readdata !== 32'h0) begin errors++; $display("FAIL rstmid_readdata got %h want 0", avs_readdata); end
    if (avs_waitrequest !== 1'b0) begin errors++; $display("FAIL rstmid_wait got %b want 0", avs_waitrequest); end
    repeat (2) @(negedge clk);
    reset = 0;
    exp_q.push_back(ref_mem[8'h50]);
    avs_rd(8'h50, d, w);
    e = exp_q.pop_front();
    checks++;
    if (d !== e) begin errors++; $display("FAIL rstmid_ram got %h want %h", d, e); end
    strobe(1, '0);
    exp_q.push_back(ref_mem[8'h00]);
    wait_ready(n);
    e = exp_q.pop_front();
    checks++;
    if (MonDReg !== e) begin errors++; $display("FAIL rstmid_areg got %h want %h", MonDReg, e); end
  endtask

  initial begin
    reset = 1; jdo = '0; ta_a = 0; tna_a = 0; ta_b = 0;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0; avs_byteenable = 4'hF;
    test_reset();
    test_jtag_write();
    test_read_wrap();
    test_collision();
    test_overrun();
    test_byteenable();
    test_back_to_back();
    test_rom_protect();
    test_reset_mid_write();
    checks++;
    if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain got %0d want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
